// File: rtl/adc_capture_pkg.sv
// adc_capture_pkg: shared widths and FSM state encoding for the ADC capture controller.
package adc_capture_pkg;
    localparam int ADC_W = 12;
    localparam int OUT_W = 13;
    typedef enum logic [1:0] {IDLE, CAL, RUN} state_t;
endpackage

// File: rtl/sample_strobe_gen.sv
// sample_strobe_gen: divides clk by I_CLK_FRQ/SPL_FRQ into a one-cycle sample strobe.
// Ports: clk, rst_n (sync, active-low), en (counter held at 0 when low), tick (strobe out).
module sample_strobe_gen #(
    parameter int I_CLK_FRQ = 96_000_000,
    parameter int SPL_FRQ   = 6_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);
    localparam int DIV = I_CLK_FRQ / SPL_FRQ;
    localparam int CW  = $clog2(DIV);
    generate
        if (DIV < 2) begin : g_div_chk
            $error("sample_strobe_gen: I_CLK_FRQ/SPL_FRQ must be at least 2");
        end
    endgenerate
    logic [CW-1:0] cnt_q;
    logic          last;
    assign last = cnt_q == CW'(DIV - 1);
    always_ff @(posedge clk) begin
        if (!rst_n || !en) cnt_q <= '0;
        else               cnt_q <= last ? '0 : cnt_q + CW'(1);
    end
    // Gated so the strobe is low while reset or disabled, whatever the count.
    assign tick = rst_n & en & last;
endmodule

// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: samples an ADC, calibrates its DC level, streams DC-removed samples.
// Ports: clk, rst_n (sync, active-low), en, start, adc_data[11:0] in;
//        sample_tick, out_data[12:0]/out_valid/out_ready handshake, dc_offset[11:0],
//        cal_done, overrun (sticky), clip_count[7:0] (only live with ADC_CLIP_DETECT_EN).
module adc_capture_ctrl
    import adc_capture_pkg::*;
#(
    parameter int I_CLK_FRQ = 96_000_000,
    parameter int SPL_FRQ   = 6_000_000,
    parameter int CAL_LOG2  = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             start,
    input  logic [ADC_W-1:0] adc_data,
    output logic             sample_tick,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ADC_W-1:0] dc_offset,
    output logic             cal_done,
    output logic             overrun,
    output logic [7:0]       clip_count
);
    localparam int ACC_W = ADC_W + CAL_LOG2;
    state_t               state_q;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [CAL_LOG2-1:0]  cnt_q;
    logic [ADC_W-1:0]     dc_q;
    logic [OUT_W-1:0]     out_q, diff_d;
    logic                 valid_q, ovr_q, tick;

    sample_strobe_gen #(.I_CLK_FRQ(I_CLK_FRQ), .SPL_FRQ(SPL_FRQ)) u_strobe (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .tick (tick)
    );

    assign acc_d  = acc_q + ACC_W'(adc_data);
    assign diff_d = {1'b0, adc_data} - {1'b0, dc_q};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            dc_q    <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else if (!en) begin
            state_q <= IDLE;
            if (valid_q && out_ready) valid_q <= 1'b0;
        end else if (start) begin
            // dc_q is deliberately kept until the new calibration completes.
            state_q <= CAL;
            acc_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            if (valid_q && out_ready) valid_q <= 1'b0;
            case (state_q)
                CAL: if (tick) begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (&cnt_q) begin
                        dc_q    <= ADC_W'(acc_d >> CAL_LOG2);
                        state_q <= RUN;
                    end
                end
                RUN: if (tick) begin
                    // A pending unaccepted sample wins; the new one is dropped.
                    if (valid_q && !out_ready) ovr_q <= 1'b1;
                    else begin
                        out_q   <= diff_d;
                        valid_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ADC_CLIP_DETECT_EN
    logic [7:0] clip_q;
    always_ff @(posedge clk) begin
        if (!rst_n || (en && start))
            clip_q <= '0;
        else if (tick && (state_q == CAL || state_q == RUN) && (adc_data == '0 || &adc_data) && clip_q != 8'hFF)
            clip_q <= clip_q + 8'd1;
    end
    assign clip_count = clip_q;
`else
    assign clip_count = '0;
`endif

    assign sample_tick = tick;
    assign out_data    = out_q;
    assign out_valid   = valid_q;
    assign dc_offset   = dc_q;
    assign cal_done    = state_q == RUN;
    assign overrun     = ovr_q;
endmodule

// File: tb/tb_adc_capture_ctrl.sv
// tb_adc_capture_ctrl: self-checking bench for adc_capture_ctrl at default parameters.
module tb_adc_capture_ctrl;
    logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0, start = 1'b0, out_ready = 1'b1;
    logic [11:0] adc_data = '0;
    logic        sample_tick, out_valid, cal_done, overrun;
    logic [12:0] out_data;
    logic [11:0] dc_offset;
    logic [7:0]  clip_count;

    adc_capture_ctrl dut (
        .clk(clk), .rst_n(rst_n), .en(en), .start(start), .adc_data(adc_data),
        .sample_tick(sample_tick), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .dc_offset(dc_offset), .cal_done(cal_done),
        .overrun(overrun), .clip_count(clip_count)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    logic [12:0] sb[$];
    typedef struct { logic [11:0] adc; logic [12:0] exp; } vec_t;
    vec_t vt[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_tick();
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = sample_tick;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL tick_timeout: got no tick expected tick within 40 cycles");
        end
    endtask

    task automatic gap(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sample_tick && n < 40);
    endtask

    task automatic expect_out(input string name);
        check({name, "_valid"}, out_valid, 1);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got empty scoreboard expected entry", name);
        end else check(name, out_data, sb.pop_front());
    endtask

    task automatic do_cal(input logic [11:0] adc, input logic [11:0] old_dc, input logic [11:0] new_dc);
        adc_data = adc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("cal_start_done", cal_done, 0);
        check("cal_start_ovr", overrun, 0);
        check("cal_start_valid", out_valid, 0);
        check("cal_keep_dc", dc_offset, old_dc);
        repeat (64) wait_tick();
        check("cal_last_done", cal_done, 0);
        check("cal_last_dc", dc_offset, old_dc);
        @(negedge clk);
        check("cal_done", cal_done, 1);
        check("cal_dc", dc_offset, new_dc);
    endtask

    initial begin
        int n, nt;
        vt[0] = '{12'h600, 13'h0060};
        vt[1] = '{12'h500, 13'h1F60};
        vt[2] = '{12'h5A0, 13'h0000};
        vt[3] = '{12'hFFF, 13'h0A5F};
        vt[4] = '{12'h000, 13'h1A60};
        vt[5] = '{12'h5A1, 13'h0001};
        vt[6] = '{12'h59F, 13'h1FFF};

        en = 1'b1;
        nt = 0;
        repeat (20) begin
            @(negedge clk);
            nt += int'(sample_tick);
        end
        check("rst_tick", nt, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_dc", dc_offset, 0);
        check("rst_cal_done", cal_done, 0);
        check("rst_overrun", overrun, 0);
        check("rst_clip", clip_count, 0);
        rst_n = 1'b1;

        wait_tick();
        gap(n);
        check("tick_gap1", n, 16);
        gap(n);
        check("tick_gap2", n, 16);
        @(negedge clk);
        en = 1'b0;
        nt = 0;
        repeat (40) begin
            @(negedge clk);
            nt += int'(sample_tick);
        end
        check("tick_en0", nt, 0);
        en = 1'b1;

        do_cal(12'h5A0, 12'h000, 12'h5A0);

        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            adc_data = vt[i].adc;
            wait_tick();
            sb.push_back(vt[i].exp);
            @(negedge clk);
            expect_out("run_vec");
            @(negedge clk);
            check("run_vec_drop", out_valid, 0);
        end

        out_ready = 1'b0;
        adc_data = 12'h600;
        wait_tick();
        sb.push_back(13'h0060);
        @(negedge clk);
        expect_out("ovr_first");
        check("ovr_before", overrun, 0);
        adc_data = 12'h500;
        wait_tick();
        @(negedge clk);
        check("ovr_set", overrun, 1);
        check("ovr_hold_valid", out_valid, 1);
        check("ovr_hold_data", out_data, 13'h0060);
        out_ready = 1'b1;
        @(negedge clk);
        check("ovr_hs_drop", out_valid, 0);
        check("ovr_sticky", overrun, 1);
        do_cal(12'h400, 12'h5A0, 12'h400);

        out_ready = 1'b0;
        adc_data = 12'h410;
        wait_tick();
        sb.push_back(13'h0010);
        @(negedge clk);
        expect_out("hs_tick_first");
        adc_data = 12'h420;
        wait_tick();
        out_ready = 1'b1;
        sb.push_back(13'h0020);
        @(negedge clk);
        expect_out("hs_tick_second");
        check("hs_tick_no_ovr", overrun, 0);
        @(negedge clk);
        check("hs_tick_drop", out_valid, 0);

        adc_data = 12'h7FF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) wait_tick();
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_tick", sample_tick, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_dc", dc_offset, 0);
        check("mid_rst_done", cal_done, 0);
        check("mid_rst_ovr", overrun, 0);
        check("mid_rst_clip", clip_count, 0);
        rst_n = 1'b1;
        do_cal(12'h123, 12'h000, 12'h123);

        adc_data = 12'hFFF;
        repeat (3) begin
            wait_tick();
            @(negedge clk);
        end
        adc_data = 12'h000;
        repeat (2) begin
            wait_tick();
            @(negedge clk);
        end
`ifdef ADC_CLIP_DETECT_EN
        check("clip_5", clip_count, 5);
`else
        check("clip_off", clip_count, 0);
`endif
        adc_data = 12'hFFF;
        repeat (300) wait_tick();
        @(negedge clk);
`ifdef ADC_CLIP_DETECT_EN
        check("clip_sat", clip_count, 255);
`else
        check("clip_off_sat", clip_count, 0);
`endif

        en = 1'b0;
        @(negedge clk);
        check("en0_idle", cal_done, 0);
        check("en0_tick", sample_tick, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/adc_capture_ctrl.md
ADC_CAPTURE_CTRL -- requirements
Module: adc_capture_ctrl

Interface
REQ-001 SHALL have parameter I_CLK_FRQ, default 96_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter SPL_FRQ, default 6_000_000, ADC sample rate in Hz.
REQ-003 SHALL have parameter CAL_LOG2, default 6, log2 of the number of DC-calibration samples.
REQ-004 SHALL have port clk  in  1  system clock, single clock domain.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port en  in  1  block enable.
REQ-007 SHALL have port start  in  1  single-cycle pulse that begins or restarts calibration.
REQ-008 SHALL have port adc_data  in  12  unsigned ADC code.
REQ-009 SHALL have port sample_tick  out  1  one-cycle sample strobe.
REQ-010 SHALL have port out_data  out  13  signed, DC-removed sample.
REQ-011 SHALL have port out_valid  out  1  out_data valid.
REQ-012 SHALL have port out_ready  in  1  consumer accepts out_data.
REQ-013 SHALL have port dc_offset  out  12  calibrated DC estimate.
REQ-014 SHALL have port cal_done  out  1  high while in RUN.
REQ-015 SHALL have port overrun  out  1  sticky dropped-sample flag.
REQ-016 SHALL have port clip_count  out  8  saturating count of clipped samples.

Function
REQ-017 SHALL define DIV = I_CLK_FRQ/SPL_FRQ, with DIV >= 2 checked at elaboration.
REQ-018 SHALL count 0..DIV-1 while en=1 and pulse sample_tick when the count equals DIV-1; with en=0 the counter SHALL be held at 0 and sample_tick SHALL stay low.
REQ-019 SHALL implement FSM states IDLE, CAL and RUN; transitions: IDLE -(start & en)-> CAL; CAL -(2^CAL_LOG2 ticks)-> RUN; any state -(en=0)-> IDLE on the next cycle.
REQ-020 SHALL, on entering CAL, clear the accumulator (12+CAL_LOG2 bits) and the sample count, clear out_valid, and clear cal_done.
REQ-021 SHALL, in CAL, add adc_data to the accumulator on each tick; on the final tick it SHALL load dc_offset = (accumulator including that sample) >> CAL_LOG2, truncated, and enter RUN in the next cycle.
REQ-022 SHALL, in RUN, on each tick, register out_data = {1'b0,adc_data} - {1'b0,dc_offset} as a 13-bit two's-complement value and set out_valid in the next cycle (latency 1).
REQ-023 SHALL hold out_data and out_valid stable until out_valid & out_ready; the cycle after the handshake, out_valid SHALL drop unless a new tick loaded a sample.
REQ-024 SHALL treat a tick coinciding with out_valid & out_ready as loading the new sample with out_valid staying 1, and no overrun.
REQ-025 SHALL handle a tick in RUN while out_valid & !out_ready as follows: drop the new sample, keep out_data, and set overrun sticky until reset or start.
REQ-026 SHALL treat start in CAL or RUN as a restart of CAL per REQ-020 and clear overrun; dc_offset SHALL retain its old value until the new calibration completes.
REQ-027 SHALL drive cal_done = 1 exactly while the FSM is in RUN.

Reset
REQ-028 SHALL, with rst_n low at a clk edge, set the FSM to IDLE and set the tick counter, accumulator, out_data, out_valid, dc_offset, cal_done, overrun and clip_count to 0; sample_tick SHALL be 0 during reset.
REQ-029 SHALL, when reset is asserted mid-CAL or in RUN, abort immediately, with no partial dc_offset update.

Configuration
REQ-030 SHALL, with ADC_CLIP_DETECT_EN defined, increment clip_count (saturating at 255) on every tick in CAL or RUN where adc_data equals 12'h000 or 12'hFFF; start SHALL clear clip_count.
REQ-031 SHALL, without ADC_CLIP_DETECT_EN, tie clip_count to 0 and include no clip logic.

Structure
REQ-032 SHALL place the FSM state enum (IDLE, CAL, RUN) and the ADC_W=12 and OUT_W=13 constants in package adc_capture_pkg.
REQ-033 SHALL implement the tick generator as sub-module sample_strobe_gen (parameters I_CLK_FRQ and SPL_FRQ; ports clk, rst_n, en, tick).

Verification
REQ-034 SHALL cover this scenario: defaults with en=1 -> sample_tick pulses every 16 clk cycles and stays low with en=0.
REQ-035 SHALL cover this scenario: start with adc_data=12'h5A0 held for 64 ticks -> dc_offset=12'h5A0 and cal_done=1 one cycle after the 64th tick.
REQ-036 SHALL cover this scenario: in RUN with out_ready=1 and adc_data=12'h600 -> out_data=+96 (13'h0060); with adc_data=12'h500 -> out_data=-160 (13'h1F60); out_valid asserts 1 cycle after the tick.
REQ-037 SHALL cover this scenario: in RUN with out_ready=0 across 2 ticks -> overrun=1 and out_data holds the first sample; a subsequent start clears overrun.
REQ-038 SHALL cover this scenario: rst_n low at the 30th CAL tick -> all outputs are 0 next cycle and the FSM is in IDLE; a fresh start recalibrates from zero.
REQ-039 SHALL cover this scenario: with ADC_CLIP_DETECT_EN defined, adc_data=12'hFFF for 3 ticks and then 12'h000 for 2 ticks -> clip_count=5; with 300 clipped ticks -> clip_count=255.
